// File: rtl/clock_gen_pkg.sv
// Shared types and reset defaults for the clock divider bank.
// The counter width is fixed here because the channel config struct is built from it.
package clock_gen_pkg;

   localparam int CNT_W        = 16;
   localparam int DIV_RST_DEF  = 1;
   localparam int HIGH_RST_DEF = 1;

   typedef struct packed {
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] high;
      logic [CNT_W-1:0] phase;
   } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: period counter, active/shadow config and registered outputs.
module clk_div_channel
   import clock_gen_pkg::*;
#(
   parameter int DIV_RST  = DIV_RST_DEF,
   parameter int HIGH_RST = HIGH_RST_DEF
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic [CNT_W-1:0] wr_high,
   input  logic [CNT_W-1:0] wr_phase,
   output logic             clk_out,
   output logic             clk_tick
);

   localparam ch_cfg_t CFG_RST = '{div: CNT_W'(DIV_RST), high: CNT_W'(HIGH_RST), phase: '0};

   ch_cfg_t          act_q;
   ch_cfg_t          shd_q;
   ch_cfg_t          act_nxt;
   logic             pend_q;
   logic             en_q;
   logic             apply;
   logic             wrap;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;

   // NOTE: every branch assigns every output, so no latch can be inferred.
   always_comb begin
      wrap    = (cnt_q == act_q.div);
      // A stopped or just-started channel has no period to finish, so it takes config at once.
      apply   = pend_q && (sync || !en || !en_q || wrap);
      act_nxt = apply ? shd_q : act_q;
      if (!en || !en_q || sync) begin
         cnt_nxt = act_nxt.phase;
      end else if (wrap) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         act_q    <= CFG_RST;
         shd_q    <= CFG_RST;
         pend_q   <= 1'b0;
         en_q     <= 1'b0;
         clk_out  <= 1'b0;
         clk_tick <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         act_q <= act_nxt;
         en_q  <= en;
         // A write landing on an apply cycle stays pending for the next apply point.
         if (wr) begin
            shd_q  <= '{div: wr_div, high: wr_high, phase: wr_phase};
            pend_q <= 1'b1;
         end else if (apply) begin
            pend_q <= 1'b0;
         end
         clk_out  <= en && (cnt_nxt < act_nxt.high);
         clk_tick <= en && (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider: config decode/validation, reset release
// synchroniser, and one clk_div_channel per output.
module clock_divider_bank
   import clock_gen_pkg::*;
#(
   parameter int  NUM_CH   = 4,
   parameter int  DIV_RST  = DIV_RST_DEF,
   parameter int  HIGH_RST = HIGH_RST_DEF,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_100M,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [CNT_W-1:0]  cfg_phase,
   output logic              cfg_err,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_in,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] clk_tick
);

   logic [1:0]       rst_pipe;
   logic             rst_int;
   logic             cfg_bad;
   logic             cfg_ok;
   logic [CNT_W-1:0] phase_st;

   // Reset asserts immediately but releases two edges later, on a clean clock boundary.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         rst_pipe <= 2'b11;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end

   assign rst_int  = rst_pipe[1];
   assign cfg_bad  = (cfg_div == '0) || (int'(cfg_ch) >= NUM_CH);
   assign cfg_ok   = cfg_we && !cfg_bad;
   assign phase_st = (cfg_phase > cfg_div) ? '0 : cfg_phase;

   always_ff @(posedge clk_100M or posedge rst_int) begin
      if (rst_int) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && cfg_bad;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .DIV_RST  (DIV_RST),
         .HIGH_RST (HIGH_RST)
      ) u_ch (
         .clk_100M (clk_100M),
         .rst      (rst_int),
         .en       (ch_en[i]),
         .sync     (sync_in),
         .wr       (cfg_ok && (int'(cfg_ch) == i)),
         .wr_div   (cfg_div),
         .wr_high  (cfg_high),
         .wr_phase (phase_st),
         .clk_out  (clk_out[i]),
         .clk_tick (clk_tick[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_clock_divider_bank;
   import clock_gen_pkg::*;

   localparam int NUM_CH = 3;
   localparam int CH_W   = 2;

   logic              clk_100M = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [CNT_W-1:0]  cfg_high;
   logic [CNT_W-1:0]  cfg_phase;
   logic              cfg_err;
   logic [NUM_CH-1:0] ch_en;
   logic              sync_in;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] clk_tick;

   int n_checks = 0;
   int n_fail   = 0;

   clock_divider_bank #(.NUM_CH(NUM_CH)) dut (
      .clk_100M  (clk_100M),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .ch_en     (ch_en),
      .sync_in   (sync_in),
      .clk_out   (clk_out),
      .clk_tick  (clk_tick)
   );

   always #5 clk_100M = ~clk_100M;

   // ---------------- behavioural reference model ----------------
   // Each channel is described by where it sits in its period (pos), its live
   // settings, and a queued setting waiting for the next legal switch point.
   int  m_div [NUM_CH], m_high [NUM_CH], m_phase [NUM_CH];
   int  q_div [NUM_CH], q_high [NUM_CH], q_phase [NUM_CH];
   bit  m_queued [NUM_CH];
   bit  m_running [NUM_CH];
   int  m_pos [NUM_CH];
   int  rst_hold;
   logic [NUM_CH-1:0] exp_out, exp_tick;
   logic              exp_err;

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_div[c] = 1; m_high[c] = 1; m_phase[c] = 0;
         q_div[c] = 1; q_high[c] = 1; q_phase[c] = 0;
         m_queued[c] = 0; m_running[c] = 0; m_pos[c] = 0;
      end
      exp_out = '0; exp_tick = '0; exp_err = 1'b0;
   endfunction

   function automatic void model_step();
      bit accept;
      accept  = cfg_we && (cfg_div != 0) && (int'(cfg_ch) < NUM_CH);
      exp_err = cfg_we && !accept;
      for (int c = 0; c < NUM_CH; c++) begin
         bit on, starting, period_end;
         on         = ch_en[c];
         starting   = on && !m_running[c];
         period_end = (m_pos[c] == m_div[c]);
         if (m_queued[c] && (sync_in || !on || starting || period_end)) begin
            m_div[c] = q_div[c]; m_high[c] = q_high[c]; m_phase[c] = q_phase[c];
            m_queued[c] = 0;
         end
         if (!on || starting || sync_in) m_pos[c] = m_phase[c];
         else m_pos[c] = period_end ? 0 : m_pos[c] + 1;
         if (accept && int'(cfg_ch) == c) begin
            q_div[c]  = int'(cfg_div);
            q_high[c] = int'(cfg_high);
            q_phase[c] = (cfg_phase > cfg_div) ? 0 : int'(cfg_phase);
            m_queued[c] = 1;
         end
         m_running[c] = on;
         exp_out[c]  = on && (m_pos[c] < m_high[c]);
         exp_tick[c] = on && (m_pos[c] == 0);
      end
   endfunction

   always @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         model_reset();
         rst_hold = 2;
      end else if (rst_hold > 0) begin
         rst_hold--;
         model_reset();
      end else begin
         model_step();
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic write_cfg(input int ch, input int div, input int high, input int phase);
      cfg_we = 1'b1; cfg_ch = CH_W'(ch);
      cfg_div = CNT_W'(div); cfg_high = CNT_W'(high); cfg_phase = CNT_W'(phase);
      @(posedge clk_100M); #1;
      cfg_we = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; ch_en = '1; cfg_we = 1'b0; sync_in = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;
      repeat (3) @(posedge clk_100M);
      #1;
      n_checks++;
      if (clk_out !== '0 || clk_tick !== '0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: out=%b tick=%b err=%b, required all zero", clk_out, clk_tick, cfg_err);
      end
      @(negedge clk_100M) rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick || cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL reset_release cyc %0d: out=%b tick=%b err=%b, required %b %b %b",
                     k, clk_out, clk_tick, cfg_err, exp_out, exp_tick, exp_err);
         end
      end
   endtask

   task automatic test_default_50m();
      logic [NUM_CH-1:0] prev;
      prev = clk_out;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick) begin
            n_fail++;
            $display("FAIL default_model cyc %0d: out=%b tick=%b, required %b %b", k, clk_out, clk_tick, exp_out, exp_tick);
         end
         n_checks++;
         if (clk_out !== ~prev || clk_tick !== clk_out) begin
            n_fail++;
            $display("FAIL default_50m cyc %0d: out=%b tick=%b prev=%b, required toggling with tick on high", k, clk_out, clk_tick, prev);
         end
         prev = clk_out;
      end
   endtask

   task automatic test_cfg_period();
      int highs, ticks;
      write_cfg(0, 9, 3, 0);
      highs = 0; ticks = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick) begin
            n_fail++;
            $display("FAIL cfg_period cyc %0d: out=%b tick=%b, required %b %b", k, clk_out, clk_tick, exp_out, exp_tick);
         end
         if (k >= 20) begin
            highs += int'(clk_out[0]);
            ticks += int'(clk_tick[0]);
         end
      end
      n_checks++;
      if (highs != 6 || ticks != 2) begin
         n_fail++;
         $display("FAIL cfg_period_duty: highs=%0d ticks=%0d in 20 cycles, required 6 and 2", highs, ticks);
      end
   endtask

   task automatic test_cfg_reject();
      write_cfg(0, 0, 2, 0);
      n_checks++;
      if (cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_div0: cfg_err=%b, required 1", cfg_err);
      end
      write_cfg(NUM_CH, 5, 2, 0);
      n_checks++;
      if (cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_ch: cfg_err=%b, required 1", cfg_err);
      end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick || cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL reject_hold cyc %0d: out=%b tick=%b err=%b, required %b %b %b",
                     k, clk_out, clk_tick, cfg_err, exp_out, exp_tick, exp_err);
         end
      end
   endtask

   task automatic test_sync_phase();
      int t1, t2;
      write_cfg(1, 3, 2, 2);
      write_cfg(2, 3, 2, 0);
      repeat (8) @(posedge clk_100M);
      #1;
      sync_in = 1'b1;
      t1 = -1; t2 = -1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk_100M); #1;
         sync_in = 1'b0;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick) begin
            n_fail++;
            $display("FAIL sync_model cyc %0d: out=%b tick=%b, required %b %b", k, clk_out, clk_tick, exp_out, exp_tick);
         end
         if (t1 < 0 && clk_tick[1]) t1 = k;
         else if (t1 >= 0 && t2 < 0 && clk_tick[2]) t2 = k;
      end
      n_checks++;
      if (t1 != 2 || t2 - t1 != 2) begin
         n_fail++;
         $display("FAIL sync_offset: ch1 tick at %0d, ch2 next tick at %0d, required 2 and 4", t1, t2);
      end
   endtask

   task automatic test_duty_clamp();
      int highs, ticks;
      for (int pass = 0; pass < 2; pass++) begin
         write_cfg(0, 9, (pass == 0) ? 0 : 20, 0);
         highs = 0; ticks = 0;
         for (int k = 0; k < 50; k++) begin
            @(posedge clk_100M); #1;
            n_checks++;
            if (clk_out !== exp_out || clk_tick !== exp_tick) begin
               n_fail++;
               $display("FAIL clamp_model pass %0d cyc %0d: out=%b tick=%b, required %b %b",
                        pass, k, clk_out, clk_tick, exp_out, exp_tick);
            end
            if (k >= 20) begin
               highs += int'(clk_out[0]);
               ticks += int'(clk_tick[0]);
            end
         end
         n_checks++;
         if (highs != ((pass == 0) ? 0 : 30) || ticks != 3) begin
            n_fail++;
            $display("FAIL duty_clamp pass %0d: highs=%0d ticks=%0d in 30 cycles, required %0d and 3",
                     pass, highs, ticks, (pass == 0) ? 0 : 30);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_ch    = CH_W'($urandom_range(0, 3));
         cfg_div   = CNT_W'($urandom_range(0, 12));
         cfg_high  = CNT_W'($urandom_range(0, 14));
         cfg_phase = CNT_W'($urandom_range(0, 14));
         sync_in   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick || cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL random cyc %0d: out=%b tick=%b err=%b, required %b %b %b",
                     k, clk_out, clk_tick, cfg_err, exp_out, exp_tick, exp_err);
         end
      end
      cfg_we = 1'b0; sync_in = 1'b0; ch_en = '1;
   endtask

   task automatic test_reset_mid();
      logic [NUM_CH-1:0] prev;
      write_cfg(0, 30, 10, 0);
      write_cfg(0, 12, 5, 3);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (clk_out !== '0 || clk_tick !== '0) begin
         n_fail++;
         $display("FAIL reset_async: out=%b tick=%b, required 0 0", clk_out, clk_tick);
      end
      repeat (2) @(posedge clk_100M);
      @(negedge clk_100M) rst = 1'b0;
      prev = '0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk_100M); #1;
         n_checks++;
         if (clk_out !== exp_out || clk_tick !== exp_tick || cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL reset_mid_model cyc %0d: out=%b tick=%b err=%b, required %b %b %b",
                     k, clk_out, clk_tick, cfg_err, exp_out, exp_tick, exp_err);
         end
         if (k >= 6) begin
            n_checks++;
            if (clk_out !== ~prev) begin
               n_fail++;
               $display("FAIL reset_mid_default cyc %0d: out=%b prev=%b, required toggling", k, clk_out, prev);
            end
         end
         prev = clk_out;
      end
   endtask

   initial begin
      test_reset();
      test_default_50m();
      test_cfg_period();
      test_cfg_reject();
      test_sync_phase();
      test_duty_clamp();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
